snn_adder_unit: RTL and testbench

//  Memory-mapped integrate-and-fire accumulator for one spiking neuron, slave to the RISC-V core bus.

---
 rtl/snn_adder_unit_if.sv | 23 ++
 rtl/snn_adder_unit.sv | 162 ++++++++++++++++
 tb/tb_snn_adder_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_adder_unit_if.sv
// Bus bundle between the RISC-V core (master) and one integrate-and-fire neuron (slave).
// Carries the read/write strobes, address and data, and the neuron's fire pulse.
interface snn_adder_unit_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  risc_v_read;
    logic                  risc_v_write;
    logic [ADDR_WIDTH-1:0] risc_v_addr;
    logic [DATA_WIDTH-1:0] risc_v_data_in;
    logic [DATA_WIDTH-1:0] risc_v_data_out;
    logic                  spike_detected;

    modport master (
        output risc_v_read, risc_v_write, risc_v_addr, risc_v_data_in,
        input  risc_v_data_out, spike_detected
    );

    modport slave (
        input  risc_v_read, risc_v_write, risc_v_addr, risc_v_data_in,
        output risc_v_data_out, spike_detected
    );
endinterface

// File: rtl/snn_adder_unit.sv
// Memory-mapped integrate-and-fire neuron: weight file, membrane, threshold, spike counter.
// Optional membrane leak is enabled by defining ADDER_UNIT_LEAK_EN.
module snn_adder_unit #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int THRESHOLD  = 1000
) (
    input  logic             clk,
    input  logic             reset,
    snn_adder_unit_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NUM_W = DEPTH - 5;

    localparam logic [ADDR_WIDTH-1:0] A_LAST_W = ADDR_WIDTH'(NUM_W - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LEAK   = ADDR_WIDTH'(DEPTH - 5);
    localparam logic [ADDR_WIDTH-1:0] A_SPIKE  = ADDR_WIDTH'(DEPTH - 4);
    localparam logic [ADDR_WIDTH-1:0] A_MEM    = ADDR_WIDTH'(DEPTH - 3);
    localparam logic [ADDR_WIDTH-1:0] A_STAT   = ADDR_WIDTH'(DEPTH - 2);
    localparam logic [ADDR_WIDTH-1:0] A_THR    = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [DATA_WIDTH-1:0] THRESH_RST = DATA_WIDTH'(THRESHOLD);
    localparam logic [DATA_WIDTH-2:0] CNT_MAX    = '1;

    logic [DATA_WIDTH-1:0] weights_q [NUM_W];
    logic [NUM_W-1:0]      w_we;

    logic [DATA_WIDTH-1:0] membrane_q, membrane_d;
    logic [DATA_WIDTH-1:0] thresh_q;
    logic [DATA_WIDTH-2:0] cnt_q, cnt_d;
    logic                  fired_q, fired_d;
    logic                  spike_q, spike_d;
    logic [DATA_WIDTH-1:0] data_out_q;

    logic [ADDR_WIDTH-1:0] spike_idx;
    logic                  spike_in_range;
    logic                  spike_ev;
    logic                  fire;
    logic [DATA_WIDTH-1:0] w_sel;
    logic [DATA_WIDTH:0]   sum_wide;
    logic [DATA_WIDTH-1:0] sum_sat;
    logic [DATA_WIDTH-1:0] sum_leak;
    logic [DATA_WIDTH-1:0] rd_data;

`ifdef ADDER_UNIT_LEAK_EN
    logic [DATA_WIDTH-1:0] leak_q;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_W; gi++) begin : g_wdec
            assign w_we[gi] = bus.risc_v_write && (bus.risc_v_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Spike path: weight is read from the pre-edge array, so a same-cycle weight write is not seen.
    always_comb begin
        spike_idx      = bus.risc_v_data_in[ADDR_WIDTH-1:0];
        spike_in_range = (spike_idx <= A_LAST_W);
        spike_ev       = bus.risc_v_write && (bus.risc_v_addr == A_SPIKE) && spike_in_range;
        w_sel          = '0;
        if (spike_in_range) begin
            w_sel = weights_q[spike_idx];
        end
        sum_wide = {1'b0, membrane_q} + {1'b0, w_sel};
        sum_sat  = sum_wide[DATA_WIDTH] ? '1 : sum_wide[DATA_WIDTH-1:0];
`ifdef ADDER_UNIT_LEAK_EN
        sum_leak = (sum_sat > leak_q) ? (sum_sat - leak_q) : '0;
`else
        sum_leak = sum_sat;
`endif
        fire = spike_ev && (sum_leak >= thresh_q);
    end

    always_comb begin
        membrane_d = membrane_q;
        cnt_d      = cnt_q;
        fired_d    = fired_q;
        spike_d    = 1'b0;
        if (bus.risc_v_write && (bus.risc_v_addr == A_MEM)) begin
            membrane_d = bus.risc_v_data_in;
        end
        if (spike_ev) begin
            if (fire) begin
                membrane_d = '0;
                fired_d    = 1'b1;
                spike_d    = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                membrane_d = sum_leak;
            end
        end
        if (bus.risc_v_write && (bus.risc_v_addr == A_STAT)) begin
            cnt_d   = '0;
            fired_d = 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        if (bus.risc_v_addr <= A_LAST_W) begin
            rd_data = weights_q[bus.risc_v_addr];
        end else begin
            case (bus.risc_v_addr)
`ifdef ADDER_UNIT_LEAK_EN
                A_LEAK:  rd_data = leak_q;
`endif
                A_MEM:   rd_data = membrane_q;
                A_STAT:  rd_data = {cnt_q, fired_q};
                A_THR:   rd_data = thresh_q;
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_W; i++) begin
            if (!reset) begin
                weights_q[i] <= '0;
            end else if (w_we[i]) begin
                weights_q[i] <= bus.risc_v_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            membrane_q <= '0;
            thresh_q   <= THRESH_RST;
            cnt_q      <= '0;
            fired_q    <= 1'b0;
            spike_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            membrane_q <= membrane_d;
            cnt_q      <= cnt_d;
            fired_q    <= fired_d;
            spike_q    <= spike_d;
            if (bus.risc_v_write && (bus.risc_v_addr == A_THR)) begin
                thresh_q <= bus.risc_v_data_in;
            end
            if (bus.risc_v_read) begin
                data_out_q <= rd_data;
            end
        end
    end

`ifdef ADDER_UNIT_LEAK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            leak_q <= '0;
        end else if (bus.risc_v_write && (bus.risc_v_addr == A_LEAK)) begin
            leak_q <= bus.risc_v_data_in;
        end
    end
`endif

    assign bus.risc_v_data_out = data_out_q;
    assign bus.spike_detected  = spike_q;
endmodule

// File: tb/tb_snn_adder_unit.sv
// Bench for snn_adder_unit: directed vector table, corner sequences, then random traffic
// against an arithmetic model of the neuron. Honors ADDER_UNIT_LEAK_EN like the design.
module tb_snn_adder_unit;
    localparam int AW = 6;
    localparam int DW = 16;
`ifdef ADDER_UNIT_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    localparam int K_W = 0;  // bus write
    localparam int K_R = 1;  // read, compare data_out
    localparam int K_S = 2;  // SPIKE_IN write, compare spike_detected
    localparam int K_I = 3;  // idle cycle, compare spike_detected

    typedef struct {
        int kind;
        int addr;
        int data;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    snn_adder_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    snn_adder_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .THRESHOLD(1000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_w [59];
    int m_mem, m_thr, m_leak, m_cnt, m_fired;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic do_write(int a, int d);
        bus_if.risc_v_write   = 1'b1;
        bus_if.risc_v_addr    = AW'(a);
        bus_if.risc_v_data_in = DW'(d);
        @(negedge clk);
        bus_if.risc_v_write   = 1'b0;
    endtask

    task automatic do_read(int a, output int d);
        bus_if.risc_v_read = 1'b1;
        bus_if.risc_v_addr = AW'(a);
        @(negedge clk);
        bus_if.risc_v_read = 1'b0;
        d = int'(bus_if.risc_v_data_out);
    endtask

    function automatic void model_reset();
        foreach (m_w[i]) m_w[i] = 0;
        m_mem = 0; m_thr = 1000; m_leak = 0; m_cnt = 0; m_fired = 0;
    endfunction

    function automatic int model_read(int a);
        if (a < 59) return m_w[a];
        case (a)
            59: return LEAK_ON ? m_leak : 0;
            61: return m_mem;
            62: return (m_cnt << 1) | m_fired;
            63: return m_thr;
            default: return 0;
        endcase
    endfunction

    function automatic void model_write(int a, int d);
        if (a < 59) m_w[a] = d;
        else if (a == 59 && LEAK_ON) m_leak = d;
        else if (a == 61) m_mem = d;
        else if (a == 62) begin m_cnt = 0; m_fired = 0; end
        else if (a == 63) m_thr = d;
    endfunction

    function automatic int model_spike(int k);
        int s;
        if (k > 58) return 0;
        s = m_mem + m_w[k];
        if (s > 65535) s = 65535;
        if (LEAK_ON) s = (s > m_leak) ? s - m_leak : 0;
        if (s >= m_thr) begin
            m_mem = 0;
            m_fired = 1;
            if (m_cnt < 32767) m_cnt++;
            return 1;
        end
        m_mem = s;
        return 0;
    endfunction

    vec_t tbl [$];

    function automatic void add(int k, int a, int d, int e);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        int got, r, a, d, e;
        bus_if.risc_v_read    = 1'b0;
        bus_if.risc_v_write   = 1'b0;
        bus_if.risc_v_addr    = '0;
        bus_if.risc_v_data_in = '0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("reset data_out", 32'(bus_if.risc_v_data_out), 0);
        check("reset spike", 32'(bus_if.spike_detected), 0);

        add(K_R, 63, 0, 1000);
        add(K_R, 61, 0, 0);
        add(K_R, 60, 0, 0);
        add(K_W, 5, 300, 0);
        add(K_R, 5, 0, 300);
        add(K_S, 5, 0, 0);     add(K_R, 61, 0, 300);
        add(K_S, 5, 0, 0);     add(K_R, 61, 0, 600);
        add(K_S, 5, 0, 0);     add(K_R, 61, 0, 900);
        add(K_S, 5, 0, 1);     add(K_I, 0, 0, 0);
        add(K_R, 61, 0, 0);    add(K_R, 62, 0, 3);
        add(K_W, 62, 0, 0);    add(K_R, 62, 0, 0);
        add(K_W, 61, 65500, 0); add(K_W, 0, 100, 0); add(K_W, 63, 65535, 0);
        add(K_S, 0, 0, 1);     add(K_R, 61, 0, 0);
        add(K_W, 61, 7, 0);
        add(K_S, 59, 0, 0);    add(K_S, 62, 0, 0);   add(K_S, 63, 0, 0);
        add(K_R, 61, 0, 7);
        add(K_R, 59, 0, 0);
        add(K_W, 59, 50, 0);   add(K_R, 59, 0, LEAK_ON ? 50 : 0);
        add(K_W, 61, 0, 0);    add(K_W, 1, 40, 0);
        add(K_S, 1, 0, 0);     add(K_R, 61, 0, LEAK_ON ? 0 : 40);
        add(K_W, 59, 0, 0);    add(K_W, 63, 0, 0);   add(K_W, 61, 0, 0);
        add(K_S, 1, 0, 1);     add(K_R, 62, 0, 5);   add(K_R, 61, 0, 0);

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                K_W: do_write(tbl[i].addr, tbl[i].data);
                K_R: begin
                    do_read(tbl[i].addr, got);
                    check($sformatf("vec%0d read[%0d]", i, tbl[i].addr), 32'(got), 32'(tbl[i].exp));
                end
                K_S: begin
                    do_write(60, tbl[i].addr);
                    check($sformatf("vec%0d spike(k=%0d)", i, tbl[i].addr),
                          32'(bus_if.spike_detected), 32'(tbl[i].exp));
                end
                default: begin
                    @(negedge clk);
                    check($sformatf("vec%0d idle spike", i), 32'(bus_if.spike_detected), 32'(tbl[i].exp));
                end
            endcase
        end

        // Reset overrides a concurrent write and clears weights and data_out.
        bus_if.risc_v_write   = 1'b1;
        bus_if.risc_v_addr    = AW'(63);
        bus_if.risc_v_data_in = DW'(7);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus_if.risc_v_write = 1'b0;
        check("reset2 data_out", 32'(bus_if.risc_v_data_out), 0);
        do_read(63, got); check("reset2 thresh", 32'(got), 1000);
        do_read(5, got);  check("reset2 weight5", 32'(got), 0);
        model_reset();

        // Read and write of the same address in one cycle return the old value.
        bus_if.risc_v_read    = 1'b1;
        bus_if.risc_v_write   = 1'b1;
        bus_if.risc_v_addr    = AW'(63);
        bus_if.risc_v_data_in = DW'(500);
        @(negedge clk);
        bus_if.risc_v_read  = 1'b0;
        bus_if.risc_v_write = 1'b0;
        check("rw same addr old", 32'(bus_if.risc_v_data_out), 1000);
        model_write(63, 500);
        do_read(63, got); check("rw same addr new", 32'(got), 500);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                a = $urandom_range(0, 63);
                e = model_spike(a);
                do_write(60, a);
                check($sformatf("rnd%0d spike(k=%0d)", n, a), 32'(bus_if.spike_detected), 32'(e));
            end else if (r <= 4) begin
                a = $urandom_range(0, 58);
                d = ($urandom_range(0, 15) == 0) ? 65535 : $urandom_range(0, 400);
                model_write(a, d);
                do_write(a, d);
            end else if (r == 5) begin
                d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(100, 2000);
                model_write(63, d);
                do_write(63, d);
            end else if (r == 6) begin
                d = ($urandom_range(0, 3) == 0) ? $urandom_range(65000, 65535) : $urandom_range(0, 1500);
                model_write(61, d);
                do_write(61, d);
            end else if (r == 7) begin
                if ($urandom_range(0, 1) == 0) begin
                    d = $urandom_range(0, 60);
                    model_write(59, d);
                    do_write(59, d);
                end else begin
                    model_write(62, 0);
                    do_write(62, $urandom_range(0, 65535));
                end
            end else begin
                a = $urandom_range(0, 63);
                e = model_read(a);
                do_read(a, got);
                check($sformatf("rnd%0d read[%0d]", n, a), 32'(got), 32'(e));
                check($sformatf("rnd%0d quiet spike", n), 32'(bus_if.spike_detected), 0);
            end
        end

        for (int a2 = 59; a2 < 64; a2++) begin
            do_read(a2, got);
            check($sformatf("final read[%0d]", a2), 32'(got), 32'(model_read(a2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
